// File: rtl/atuadores.sv
// Actuator executor for the pipe-cleaner robot: turns avancar/girar/remover into timed
// wheel/brush actions followed by a settling pause. Optional odometry under ODOMETRIA_EN.
module atuadores #(
  parameter int LARG_CNT       = 8,
  parameter int AVANCO_CICLOS  = 8,
  parameter int GIRO_CICLOS    = 12,
  parameter int REMOCAO_CICLOS = 20,
  parameter int PAUSA_CICLOS   = 2
) (
  input  logic        clockc2,
  input  logic        reset,
  input  logic        avancar,
  input  logic        girar,
  input  logic        remover,
  input  logic        parar,
  output logic        motor_esq,
  output logic        motor_dir,
  output logic        sentido_esq,
  output logic        sentido_dir,
  output logic        escova,
  output logic        ocupado,
  output logic        concluido
`ifdef ODOMETRIA_EN
  ,
  output logic [15:0] passos,
  output logic [1:0]  giros
`endif
);

  localparam logic [2:0] OCIOSO = 3'd0;
  localparam logic [2:0] AVANCA = 3'd1;
  localparam logic [2:0] GIRA   = 3'd2;
  localparam logic [2:0] REMOVE = 3'd3;
  localparam logic [2:0] PAUSA  = 3'd4;

  // Counter load value: a zero-length phase still lasts one cycle.
  function automatic logic [LARG_CNT-1:0] carga(input int ciclos);
    if (ciclos <= 0) begin
      carga = {LARG_CNT{1'b0}};
    end else begin
      carga = LARG_CNT'(ciclos - 1);
    end
  endfunction

  localparam logic [LARG_CNT-1:0] CARGA_AVANCO  = carga(AVANCO_CICLOS);
  localparam logic [LARG_CNT-1:0] CARGA_GIRO    = carga(GIRO_CICLOS);
  localparam logic [LARG_CNT-1:0] CARGA_REMOCAO = carga(REMOCAO_CICLOS);
  localparam logic [LARG_CNT-1:0] CARGA_PAUSA   = carga(PAUSA_CICLOS);
  localparam logic [LARG_CNT-1:0] CNT_UM        = LARG_CNT'(1);
  localparam logic [LARG_CNT-1:0] CNT_ZERO      = {LARG_CNT{1'b0}};

  logic [2:0]          estado_q, estado_d;
  logic [LARG_CNT-1:0] cnt_q, cnt_d;
  logic                motor_esq_q, motor_esq_d;
  logic                motor_dir_q, motor_dir_d;
  logic                sentido_esq_q, sentido_esq_d;
  logic                sentido_dir_q, sentido_dir_d;
  logic                escova_q, escova_d;
  logic                ocupado_q, ocupado_d;
  logic                concluido_q, concluido_d;

  // Next-state and counter: abort beats everything except reset; commands only in OCIOSO.
  always_comb begin
    estado_d    = estado_q;
    cnt_d       = cnt_q;
    concluido_d = 1'b0;
    if (estado_q != OCIOSO && parar) begin
      estado_d = OCIOSO;
      cnt_d    = CNT_ZERO;
    end else begin
      case (estado_q)
        OCIOSO: begin
          if (parar) begin
            estado_d = OCIOSO;
          end else if (remover) begin
            estado_d = REMOVE;
            cnt_d    = CARGA_REMOCAO;
          end else if (girar) begin
            estado_d = GIRA;
            cnt_d    = CARGA_GIRO;
          end else if (avancar) begin
            estado_d = AVANCA;
            cnt_d    = CARGA_AVANCO;
          end else begin
            estado_d = OCIOSO;
          end
        end
        AVANCA, GIRA, REMOVE: begin
          if (cnt_q == CNT_ZERO) begin
            estado_d = PAUSA;
            cnt_d    = CARGA_PAUSA;
          end else begin
            cnt_d = cnt_q - CNT_UM;
          end
        end
        PAUSA: begin
          if (cnt_q == CNT_ZERO) begin
            estado_d    = OCIOSO;
            cnt_d       = CNT_ZERO;
            concluido_d = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_UM;
          end
        end
        default: begin
          estado_d = OCIOSO;
          cnt_d    = CNT_ZERO;
        end
      endcase
    end
  end

  // Actuator pattern decoded from the next state so outputs register alongside it.
  always_comb begin
    motor_esq_d   = 1'b0;
    motor_dir_d   = 1'b0;
    sentido_esq_d = 1'b0;
    sentido_dir_d = 1'b0;
    escova_d      = 1'b0;
    ocupado_d     = (estado_d != OCIOSO);
    case (estado_d)
      AVANCA: begin
        motor_esq_d   = 1'b1;
        motor_dir_d   = 1'b1;
        sentido_esq_d = 1'b1;
        sentido_dir_d = 1'b1;
      end
      GIRA: begin
        motor_esq_d   = 1'b1;
        motor_dir_d   = 1'b1;
        sentido_esq_d = 1'b1;
      end
      REMOVE: begin
        escova_d = 1'b1;
      end
      default: begin
        escova_d = 1'b0;
      end
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge clockc2) begin
    if (reset) begin
      estado_q      <= OCIOSO;
      cnt_q         <= CNT_ZERO;
      motor_esq_q   <= 1'b0;
      motor_dir_q   <= 1'b0;
      sentido_esq_q <= 1'b0;
      sentido_dir_q <= 1'b0;
      escova_q      <= 1'b0;
      ocupado_q     <= 1'b0;
      concluido_q   <= 1'b0;
    end else begin
      estado_q      <= estado_d;
      cnt_q         <= cnt_d;
      motor_esq_q   <= motor_esq_d;
      motor_dir_q   <= motor_dir_d;
      sentido_esq_q <= sentido_esq_d;
      sentido_dir_q <= sentido_dir_d;
      escova_q      <= escova_d;
      ocupado_q     <= ocupado_d;
      concluido_q   <= concluido_d;
    end
  end

  assign motor_esq   = motor_esq_q;
  assign motor_dir   = motor_dir_q;
  assign sentido_esq = sentido_esq_q;
  assign sentido_dir = sentido_dir_q;
  assign escova      = escova_q;
  assign ocupado     = ocupado_q;
  assign concluido   = concluido_q;

`ifdef ODOMETRIA_EN
  logic [2:0]  acao_q, acao_d;
  logic [15:0] passos_q, passos_d;
  logic [1:0]  giros_q, giros_d;

  // Remember which action is running so its completion can be credited.
  always_comb begin
    if (estado_q == OCIOSO && estado_d != OCIOSO) begin
      acao_d = estado_d;
    end else begin
      acao_d = acao_q;
    end
    if (concluido_d && acao_q == AVANCA) begin
      passos_d = passos_q + 16'd1;
    end else begin
      passos_d = passos_q;
    end
    if (concluido_d && acao_q == GIRA) begin
      giros_d = giros_q + 2'd1;
    end else begin
      giros_d = giros_q;
    end
  end

  // Odometry registers.
  always_ff @(posedge clockc2) begin
    if (reset) begin
      acao_q   <= OCIOSO;
      passos_q <= 16'd0;
      giros_q  <= 2'd0;
    end else begin
      acao_q   <= acao_d;
      passos_q <= passos_d;
      giros_q  <= giros_d;
    end
  end

  assign passos = passos_q;
  assign giros  = giros_q;
`endif

endmodule

// File: tb/tb_atuadores.sv
// Self-checking bench for atuadores: directed scenarios plus randomized traffic against
// a queue-based reference model of expected per-cycle outputs.
module tb_atuadores;

  logic clk = 1'b0;
  logic reset, avancar, girar, remover, parar;
  logic motor_esq, motor_dir, sentido_esq, sentido_dir, escova, ocupado, concluido;
`ifdef ODOMETRIA_EN
  logic [15:0] passos;
  logic [1:0]  giros;
  logic [15:0] exp_passos;
  logic [1:0]  exp_giros;
`endif

  int nvec = 0;
  int nerr = 0;

  // Model item: [8:7] action kind credited on completion (1 avanca, 2 gira),
  // [6:0] {motor_esq, motor_dir, sentido_esq, sentido_dir, escova, ocupado, concluido}
  logic [8:0] cur;
  logic [8:0] fila[$];
  logic [6:0] obs;

  assign obs = {motor_esq, motor_dir, sentido_esq, sentido_dir, escova, ocupado, concluido};

  always #5 clk = ~clk;

  atuadores dut (
    .clockc2(clk), .reset(reset), .avancar(avancar), .girar(girar), .remover(remover),
    .parar(parar), .motor_esq(motor_esq), .motor_dir(motor_dir), .sentido_esq(sentido_esq),
    .sentido_dir(sentido_dir), .escova(escova), .ocupado(ocupado), .concluido(concluido)
`ifdef ODOMETRIA_EN
    , .passos(passos), .giros(giros)
`endif
  );

  // Advance model and DUT by one edge; inputs are those currently applied.
  task automatic step();
    logic [8:0] nxt;
    logic [4:0] padrao;
    int len;
    logic [1:0] tipo;
    if (reset) begin
      fila.delete();
      nxt = 9'd0;
    end else if (cur[1] && parar) begin
      fila.delete();
      nxt = 9'd0;
    end else if (!cur[1] && !parar && (remover || girar || avancar)) begin
      if (remover) begin
        padrao = 5'b00001; len = 20; tipo = 2'd0;
      end else if (girar) begin
        padrao = 5'b11100; len = 12; tipo = 2'd2;
      end else begin
        padrao = 5'b11110; len = 8; tipo = 2'd1;
      end
      fila.delete();
      nxt = {2'd0, padrao, 2'b10};
      for (int i = 1; i < len; i++) fila.push_back({2'd0, padrao, 2'b10});
      for (int i = 0; i < 2; i++) fila.push_back(9'b00_00000_10);
      fila.push_back({tipo, 5'b00000, 2'b01});
    end else if (fila.size() > 0) begin
      nxt = fila.pop_front();
    end else begin
      nxt = 9'd0;
    end
`ifdef ODOMETRIA_EN
    if (reset) begin
      exp_passos = 16'd0;
      exp_giros  = 2'd0;
    end else if (nxt[0] && nxt[8:7] == 2'd1) begin
      exp_passos = exp_passos + 16'd1;
    end else if (nxt[0] && nxt[8:7] == 2'd2) begin
      exp_giros = exp_giros + 2'd1;
    end
`endif
    @(posedge clk);
    cur = nxt;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      nvec++;
      if (obs !== 7'd0) begin
        nerr++;
        $display("FAIL reset_idle cycle %0d: got %b want %b", i, obs, 7'd0);
      end
    end
  endtask

  task automatic test_avanco();
    logic [6:0] esperado;
    avancar = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      avancar = 1'b0;
      if (k <= 8) esperado = 7'b1111010;
      else if (k <= 10) esperado = 7'b0000010;
      else if (k == 11) esperado = 7'b0000001;
      else esperado = 7'b0000000;
      nvec++;
      if (obs !== esperado || obs !== cur[6:0]) begin
        nerr++;
        $display("FAIL avanco N+%0d: got %b want %b model %b", k, obs, esperado, cur[6:0]);
      end
    end
  endtask

  task automatic test_prioridade();
    avancar = 1'b1; girar = 1'b1; remover = 1'b1;
    step();
    avancar = 1'b0; remover = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      nvec++;
      if (obs !== 7'b0000110) begin
        nerr++;
        $display("FAIL prioridade_remove cycle %0d: got %b want %b", k, obs, 7'b0000110);
      end
      step();
    end
    // girar stays held: REMOVE pause, concluido, then GIRA retriggers repeatedly
    for (int k = 0; k < 40; k++) begin
      nvec++;
      if (obs !== cur[6:0] || (motor_dir && sentido_dir)) begin
        nerr++;
        $display("FAIL prioridade_gira cycle %0d: got %b want %b", k, obs, cur[6:0]);
      end
      step();
    end
    girar = 1'b0;
    for (int k = 0; k < 20; k++) step();
  endtask

  task automatic test_abort();
`ifdef ODOMETRIA_EN
    logic [1:0] giros_antes;
    giros_antes = giros;
`endif
    girar = 1'b1;
    step();
    girar = 1'b0;
    for (int k = 1; k < 5; k++) step();
    nvec++;
    if (obs !== 7'b1110010) begin
      nerr++;
      $display("FAIL abort_gira5: got %b want %b", obs, 7'b1110010);
    end
    parar = 1'b1;
    step();
    parar = 1'b0;
    for (int k = 0; k < 16; k++) begin
      nvec++;
      if (obs !== 7'd0 || cur[6:0] !== 7'd0) begin
        nerr++;
        $display("FAIL abort_idle cycle %0d: got %b want %b", k, obs, 7'd0);
      end
`ifdef ODOMETRIA_EN
      nvec++;
      if (giros !== giros_antes) begin
        nerr++;
        $display("FAIL abort_giros: got %0d want %0d", giros, giros_antes);
      end
`endif
      step();
    end
  endtask

  task automatic test_reset_meio();
    remover = 1'b1;
    step();
    remover = 1'b0;
    for (int k = 1; k < 7; k++) step();
    reset = 1'b1;
    step();
    nvec++;
    if (obs !== 7'd0) begin
      nerr++;
      $display("FAIL reset_meio: got %b want %b", obs, 7'd0);
    end
    reset = 1'b0;
    step();
    avancar = 1'b1;
    step();
    avancar = 1'b0;
    nvec++;
    if (obs !== 7'b1111010) begin
      nerr++;
      $display("FAIL reset_meio_aceite: got %b want %b", obs, 7'b1111010);
    end
    for (int k = 0; k < 12; k++) begin
      step();
      nvec++;
      if (obs !== cur[6:0]) begin
        nerr++;
        $display("FAIL reset_meio_seq cycle %0d: got %b want %b", k, obs, cur[6:0]);
      end
    end
  endtask

  task automatic test_aleatorio();
    for (int k = 0; k < 2000; k++) begin
      avancar = ($urandom_range(0, 3) == 0);
      girar   = ($urandom_range(0, 5) == 0);
      remover = ($urandom_range(0, 7) == 0);
      parar   = ($urandom_range(0, 39) == 0);
      reset   = ($urandom_range(0, 249) == 0);
      step();
      nvec++;
      if (obs !== cur[6:0] || (escova && (motor_esq || motor_dir)) ||
          (!ocupado && (motor_esq || motor_dir || sentido_esq || sentido_dir || escova))) begin
        nerr++;
        $display("FAIL aleatorio cycle %0d: got %b want %b", k, obs, cur[6:0]);
      end
`ifdef ODOMETRIA_EN
      nvec++;
      if (passos !== exp_passos || giros !== exp_giros) begin
        nerr++;
        $display("FAIL aleatorio_odo cycle %0d: got %0d/%0d want %0d/%0d",
                 k, passos, giros, exp_passos, exp_giros);
      end
`endif
    end
    {avancar, girar, remover, parar, reset} = 5'd0;
    for (int k = 0; k < 30; k++) step();
  endtask

`ifdef ODOMETRIA_EN
  task automatic test_odometria();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int n = 0; n < 5; n++) begin
      girar = 1'b1;
      step();
      girar = 1'b0;
      for (int k = 0; k < 15; k++) step();
    end
    nvec++;
    if (giros !== 2'd1) begin
      nerr++;
      $display("FAIL odometria_giros: got %0d want 1", giros);
    end
    force dut.passos_q = 16'hFFFF;
    step();
    release dut.passos_q;
    exp_passos = 16'hFFFF;
    avancar = 1'b1;
    step();
    avancar = 1'b0;
    for (int k = 0; k < 11; k++) step();
    nvec++;
    if (passos !== 16'h0000 || exp_passos !== 16'h0000) begin
      nerr++;
      $display("FAIL odometria_wrap: got %h want 0000", passos);
    end
  endtask
`endif

  initial begin
    cur = 9'd0;
    {avancar, girar, remover, parar} = 4'd0;
    reset = 1'b1;
`ifdef ODOMETRIA_EN
    exp_passos = 16'd0;
    exp_giros  = 2'd0;
`endif
    @(negedge clk);
    test_reset();
    test_avanco();
    test_prioridade();
    test_abort();
    test_reset_meio();
    test_aleatorio();
`ifdef ODOMETRIA_EN
    test_odometria();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
